commutation_sequencer: RTL and testbench

- Per-load-phase PWM scheduler for the matrix-converter commutation FSM.
- Each switching period of `period` clocks is split into three dwell segments, one per input phase: A, then B, then C.
- Drives the FSM's `DesiredLoad`/`start` inputs and holds off segments too short for a safe 4-step commutation.
- Latches short faults and validates double-buffered dwell configuration at period boundaries.

---
 rtl/matconv_pkg.sv | 23 ++
 rtl/dwell_cfg_check.sv | 33 +++
 rtl/commutation_sequencer.sv | 169 ++++++++++++++++
 tb/tb_commutation_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matconv_pkg.sv
// Shared types and constants for the matrix-converter commutation path.
package matconv_pkg;

    localparam logic [1:0] LD_NUL = 2'b00;
    localparam logic [1:0] LD_A   = 2'b01;
    localparam logic [1:0] LD_B   = 2'b10;
    localparam logic [1:0] LD_C   = 2'b11;

    // Worst-case FSM hop count for one 4-step commutation.
    localparam int MIN_COMMUTE_STEPS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FAULT = 2'd3
    } seq_state_t;

    function automatic logic [1:0] seg_code(input logic [1:0] seg);
        return LD_A + seg;
    endfunction

endpackage

// File: rtl/dwell_cfg_check.sv
// Combinational validity check of a dwell triple against its period.
module dwell_cfg_check
    import matconv_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int MIN_DWELL = 8
) (
    input  logic [CNT_W-1:0] period_i,
    input  logic [CNT_W-1:0] dwell_a_i,
    input  logic [CNT_W-1:0] dwell_b_i,
    input  logic [CNT_W-1:0] dwell_c_i,
    output logic             valid_o
);

    localparam int MIN_EFF = (MIN_DWELL > MIN_COMMUTE_STEPS) ?
                             MIN_DWELL : MIN_COMMUTE_STEPS;
    localparam logic [CNT_W-1:0] MIN_D = CNT_W'(MIN_EFF);

    logic [CNT_W+1:0] sum;
    logic             ok_a;
    logic             ok_b;
    logic             ok_c;

    assign sum  = {2'b00, dwell_a_i} + {2'b00, dwell_b_i}
                + {2'b00, dwell_c_i};
    assign ok_a = (dwell_a_i == '0) || (dwell_a_i >= MIN_D);
    assign ok_b = (dwell_b_i == '0) || (dwell_b_i >= MIN_D);
    assign ok_c = (dwell_c_i == '0) || (dwell_c_i >= MIN_D);

    assign valid_o = (sum == {2'b00, period_i}) && ok_a && ok_b
                     && ok_c && (period_i >= MIN_D);

endmodule

// File: rtl/commutation_sequencer.sv
// Per-period A/B/C dwell scheduler driving the commutation FSM inputs.
module commutation_sequencer
    import matconv_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int MIN_DWELL = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_load,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] dwell_a,
    input  logic [CNT_W-1:0] dwell_b,
    input  logic [CNT_W-1:0] dwell_c,
    input  logic             short_in,
    input  logic             fault_clr,
    output logic [1:0]       desired_load,
    output logic             fsm_start,
    output logic             period_tick,
    output logic             busy,
    output logic             cfg_err,
    output logic             fault
);

    typedef logic [2:0][CNT_W-1:0] dwells_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    seq_state_t       state_q, state_d;
    dwells_t          stg_q, stg_d;
    dwells_t          act_q, act_d;
    dwells_t          base;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       seg_q, seg_d;
    logic [1:0]       ld_q, ld_d;
    logic             tick_q, tick_d;
    logic             sv_q, sv_d;
    logic             err_q, err_d;
    logic             cfg_ok;
    logic             nxt_ok;
    logic [1:0]       nxt_seg;
    logic [1:0]       first_seg;
    logic             go;

    dwell_cfg_check #(
        .CNT_W    (CNT_W),
        .MIN_DWELL(MIN_DWELL)
    ) u_chk (
        .period_i (period),
        .dwell_a_i(dwell_a),
        .dwell_b_i(dwell_b),
        .dwell_c_i(dwell_c),
        .valid_o  (cfg_ok)
    );

    // Config the next period will run from.
    assign base = sv_q ? stg_q : act_q;

    always_comb begin
        nxt_ok    = 1'b0;
        nxt_seg   = 2'd0;
        first_seg = 2'd0;
        for (int i = 2; i >= 0; i--) begin
            if (2'(i) > seg_q && act_q[i] != '0) begin
                nxt_ok  = 1'b1;
                nxt_seg = 2'(i);
            end
            if (base[i] != '0) begin
                first_seg = 2'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        stg_d   = stg_q;
        act_d   = act_q;
        cnt_d   = cnt_q;
        seg_d   = seg_q;
        ld_d    = ld_q;
        tick_d  = 1'b0;
        sv_d    = sv_q;
        err_d   = err_q;
        go      = 1'b0;
        if (cfg_load && !short_in) begin
            if (cfg_ok) begin
                stg_d = {dwell_c, dwell_b, dwell_a};
                sv_d  = 1'b1;
                err_d = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
        case (state_q)
            IDLE: begin
                if (start && sv_q) begin
                    go      = 1'b1;
                    state_d = RUN;
                end
            end
            RUN, DRAIN: begin
                if (stop) state_d = DRAIN;
                if (cnt_q > ONE) begin
                    cnt_d = cnt_q - ONE;
                end else if (nxt_ok) begin
                    seg_d = nxt_seg;
                    cnt_d = act_q[nxt_seg];
                    ld_d  = seg_code(nxt_seg);
                end else if (!start || stop || state_q == DRAIN) begin
                    state_d = IDLE;
                    ld_d    = LD_NUL;
                end else begin
                    go = 1'b1;
                end
            end
            FAULT: begin
                if (fault_clr && !short_in) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (go) begin
            act_d  = base;
            seg_d  = first_seg;
            cnt_d  = base[first_seg];
            ld_d   = seg_code(first_seg);
            tick_d = 1'b1;
        end
        // A short overrides everything decided above.
        if (short_in) begin
            state_d = FAULT;
            ld_d    = LD_NUL;
            tick_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            stg_q   <= '0;
            act_q   <= '0;
            cnt_q   <= '0;
            seg_q   <= 2'd0;
            ld_q    <= LD_NUL;
            tick_q  <= 1'b0;
            sv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stg_q   <= stg_d;
            act_q   <= act_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
            ld_q    <= ld_d;
            tick_q  <= tick_d;
            sv_q    <= sv_d;
            err_q   <= err_d;
        end
    end

    assign desired_load = ld_q;
    assign period_tick  = tick_q;
    assign cfg_err      = err_q;
    assign fsm_start    = (state_q == RUN) || (state_q == DRAIN);
    assign busy         = (state_q != IDLE);
    assign fault        = (state_q == FAULT);

endmodule

// File: tb/tb_commutation_sequencer.sv
// Randomized and directed bench against a period-position reference model.
module tb_commutation_sequencer;

    localparam int W    = 16;
    localparam int MIND = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         cfg_load = 1'b0;
    logic         short_in = 1'b0;
    logic         fault_clr = 1'b0;
    logic [W-1:0] period = '0;
    logic [W-1:0] dwell_a = '0;
    logic [W-1:0] dwell_b = '0;
    logic [W-1:0] dwell_c = '0;
    logic [1:0]   desired_load;
    logic         fsm_start;
    logic         period_tick;
    logic         busy;
    logic         cfg_err;
    logic         fault;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    commutation_sequencer #(.CNT_W(W), .MIN_DWELL(MIND)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .cfg_load    (cfg_load),
        .period      (period),
        .dwell_a     (dwell_a),
        .dwell_b     (dwell_b),
        .dwell_c     (dwell_c),
        .short_in    (short_in),
        .fault_clr   (fault_clr),
        .desired_load(desired_load),
        .fsm_start   (fsm_start),
        .period_tick (period_tick),
        .busy        (busy),
        .cfg_err     (cfg_err),
        .fault       (fault)
    );

    // Reference model: position within the period picks the phase.
    bit         m_run, m_drain, m_fault, m_sv, m_err, m_tick;
    int         m_stg[3];
    int         m_act[3];
    int         m_pos;
    logic [1:0] m_ld;

    function automatic logic [1:0] code_at(int p);
        if (p < m_act[0]) return 2'b01;
        if (p < m_act[0] + m_act[1]) return 2'b10;
        return 2'b11;
    endfunction

    function automatic logic [6:0] obs();
        return {desired_load, fsm_start, period_tick, busy, cfg_err, fault};
    endfunction

    function automatic logic [6:0] expv();
        return {m_ld, m_run, m_tick, m_run | m_fault, m_err, m_fault};
    endfunction

    task automatic model_step();
        int ns[3];
        int a, b, c, p;
        bit nsv, nerr;
        if (rst) begin
            m_run = 0; m_drain = 0; m_fault = 0; m_sv = 0;
            m_err = 0; m_tick = 0; m_pos = 0; m_ld = 2'b00;
            m_stg = '{0, 0, 0}; m_act = '{0, 0, 0};
            return;
        end
        ns = m_stg; nsv = m_sv; nerr = m_err;
        a = int'(dwell_a); b = int'(dwell_b);
        c = int'(dwell_c); p = int'(period);
        if (cfg_load && !short_in) begin
            if (a + b + c == p && p >= MIND && (a == 0 || a >= MIND)
                && (b == 0 || b >= MIND) && (c == 0 || c >= MIND)) begin
                ns = '{a, b, c}; nsv = 1; nerr = 0;
            end else begin
                nerr = 1;
            end
        end
        m_tick = 0;
        if (short_in) begin
            m_fault = 1; m_run = 0; m_drain = 0; m_ld = 2'b00;
        end else if (m_fault) begin
            if (fault_clr) m_fault = 0;
        end else if (!m_run) begin
            if (start && m_sv) begin
                m_act = m_stg; m_pos = 0; m_run = 1; m_tick = 1;
                m_ld = code_at(0);
            end
        end else begin
            if (stop) m_drain = 1;
            if (m_pos + 1 < m_act[0] + m_act[1] + m_act[2]) begin
                m_pos++;
                m_ld = code_at(m_pos);
            end else if (!start || m_drain) begin
                m_run = 0; m_drain = 0; m_ld = 2'b00;
            end else begin
                m_act = m_stg; m_pos = 0; m_tick = 1;
                m_ld = code_at(0);
            end
        end
        m_stg = ns; m_sv = nsv; m_err = nerr;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic load(int p, int a, int b, int c);
        period = W'(p); dwell_a = W'(a); dwell_b = W'(b); dwell_c = W'(c);
        cfg_load = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        checks++;
        if (obs() !== 7'b0) begin
            failures++;
            $display("FAIL reset got=%b exp=%b", obs(), 7'b0);
        end
        rst = 1'b0;
        cyc();
        checks++;
        if (obs() !== expv()) begin
            failures++;
            $display("FAIL reset_idle got=%b exp=%b", obs(), expv());
        end
    endtask

    task automatic test_basic();
        load(30, 10, 10, 10);
        start = 1'b1;
        for (int i = 0; i < 100; i++) begin
            cyc();
            cfg_load = 1'b0;
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL basic cyc=%0d got=%b exp=%b", i, obs(), expv());
            end
        end
    endtask

    task automatic test_single();
        load(20, 0, 20, 0);
        for (int i = 0; i < 80; i++) begin
            cyc();
            cfg_load = 1'b0;
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL single cyc=%0d got=%b exp=%b", i, obs(), expv());
            end
            if (i >= 35) begin
                checks++;
                if (desired_load !== 2'b10) begin
                    failures++;
                    $display("FAIL single_b cyc=%0d got=%b exp=10", i, desired_load);
                end
            end
        end
    endtask

    task automatic test_bad_cfg();
        for (int i = 0; i < 60; i++) begin
            if (i == 3) load(30, 5, 15, 10);
            if (i == 20) load(30, 10, 10, 11);
            cyc();
            cfg_load = 1'b0;
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL bad_cfg cyc=%0d got=%b exp=%b", i, obs(), expv());
            end
        end
    endtask

    task automatic test_reload();
        for (int i = 0; i < 150; i++) begin
            if (i == 0) load(30, 10, 10, 10);
            if (i == 45) load(40, 8, 16, 16);
            cyc();
            cfg_load = 1'b0;
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL reload cyc=%0d got=%b exp=%b", i, obs(), expv());
            end
        end
    endtask

    task automatic test_fault();
        int n = 0;
        while (m_ld != 2'b10 && n < 100) begin
            cyc();
            n++;
        end
        checks++;
        if (n >= 100) begin
            failures++;
            $display("FAIL fault_wait got=timeout exp=segment_B");
        end
        for (int i = 0; i < 50; i++) begin
            short_in  = (i == 0 || i == 4);
            fault_clr = (i == 4 || i == 5);
            cyc();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL fault cyc=%0d got=%b exp=%b", i, obs(), expv());
            end
        end
        short_in = 1'b0;
        fault_clr = 1'b0;
    endtask

    task automatic test_stop();
        int n = 0;
        start = 1'b0;
        while (m_run && n < 60) begin
            cyc();
            n++;
        end
        checks++;
        if (n >= 60) begin
            failures++;
            $display("FAIL stop_wait got=timeout exp=idle");
        end
        load(30, 10, 10, 10);
        cyc();
        cfg_load = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 45; i++) begin
            stop = (i == 3);
            cyc();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL stop cyc=%0d got=%b exp=%b", i, obs(), expv());
            end
        end
        stop = 1'b0;
    endtask

    task automatic test_rst_mid();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if (obs() !== 7'b0) begin
            failures++;
            $display("FAIL rst_mid got=%b exp=%b", obs(), 7'b0);
        end
        for (int i = 0; i < 50; i++) begin
            if (i == 20) load(24, 8, 8, 8);
            cyc();
            cfg_load = 1'b0;
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL rst_run cyc=%0d got=%b exp=%b", i, obs(), expv());
            end
        end
    endtask

    function automatic logic [W-1:0] rnd_dwell();
        int r = int'($urandom_range(15));
        if (r < 3) return '0;
        if (r == 3) return W'($urandom_range(7, 1));
        return W'($urandom_range(20, 8));
    endfunction

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(999) == 0);
            start     = ($urandom_range(49) != 0);
            stop      = ($urandom_range(39) == 0);
            short_in  = ($urandom_range(299) == 0);
            fault_clr = ($urandom_range(7) == 0);
            cfg_load  = ($urandom_range(29) == 0);
            if (cfg_load) begin
                dwell_a = rnd_dwell();
                dwell_b = rnd_dwell();
                dwell_c = rnd_dwell();
                period  = dwell_a + dwell_b + dwell_c;
                if ($urandom_range(5) == 0) period = period + W'(1);
            end
            cyc();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL random cyc=%0d got=%b exp=%b", i, obs(), expv());
            end
        end
        rst = 1'b0; stop = 1'b0; short_in = 1'b0;
        fault_clr = 1'b0; cfg_load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_bad_cfg();
        test_reload();
        test_fault();
        test_stop();
        test_rst_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
